// File: rtl/lmsm_sequencer_if.sv
// Handshake/bus bundle between the IF/ID stage and the LM/SM sequencer.
// The master modport drives the instruction side; the slave modport is the sequencer.
interface lmsm_sequencer_if;
    logic [15:0] ir_in;
    logic [15:0] pc_in;
    logic        valid_in;
    logic        stall_in;
    logic        flush;
    logic [15:0] ir_out;
    logic [15:0] pc_out;
    logic        valid_out;
    logic        busy;
    logic [2:0]  xfer_idx;
    logic        last_xfer;

    modport master (
        output ir_in, pc_in, valid_in, stall_in, flush,
        input  ir_out, pc_out, valid_out, busy, xfer_idx, last_xfer
    );

    modport slave (
        input  ir_in, pc_in, valid_in, stall_in, flush,
        output ir_out, pc_out, valid_out, busy, xfer_idx, last_xfer
    );
endinterface

// File: rtl/lmsm_sequencer.sv
// LM/SM micro-sequencer: expands a multi-register load/store into one decode op per
// mask bit (lowest register first); every other instruction passes through in one cycle.
module lmsm_sequencer (
    input  logic                    clk,
    input  logic                    rst_n,
    lmsm_sequencer_if.slave         bus
);
    typedef enum logic {IDLE = 1'b0, SEQ = 1'b1} state_e;

    localparam logic [15:0] BUBBLE = 16'hF000;

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [2:0]  idx_q, idx_d;
    logic        last_q, last_d;

    logic [7:0]  mask_nxt;
    logic        nxt_single;
    logic        in_lmsm;
    logic        in_multi;
    logic        start;

    // Mask left after retiring the lowest set bit; one bit left means the next op is the last.
    assign mask_nxt   = ir_q[7:0] & (ir_q[7:0] - 8'd1);
    assign nxt_single = (mask_nxt != 8'd0) && ((mask_nxt & (mask_nxt - 8'd1)) == 8'd0);

    assign in_lmsm  = (bus.ir_in[15:13] == 3'b011);
    assign in_multi = ((bus.ir_in[7:0] & (bus.ir_in[7:0] - 8'd1)) != 8'd0);
    assign start    = bus.valid_in && in_lmsm && in_multi;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = IDLE;
        end else if (!bus.stall_in) begin
            case (state_q)
                IDLE:    if (start)      state_d = SEQ;
                SEQ:     if (nxt_single) state_d = IDLE;
                default:                 state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        ir_d    = ir_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        last_d  = last_q;
        if (bus.flush) begin
            // pc_out is left alone on a flush; the bubble makes it irrelevant.
            ir_d    = BUBBLE;
            valid_d = 1'b0;
            idx_d   = 3'd0;
            last_d  = 1'b1;
        end else if (!bus.stall_in) begin
            case (state_q)
                IDLE: begin
                    ir_d    = bus.ir_in;
                    pc_d    = bus.pc_in;
                    valid_d = bus.valid_in;
                    idx_d   = 3'd0;
                    last_d  = !start;
                end
                SEQ: begin
                    ir_d    = {ir_q[15:8], mask_nxt};
                    valid_d = 1'b1;
                    idx_d   = idx_q + 3'd1;
                    last_d  = nxt_single;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ir_q    <= BUBBLE;
            pc_q    <= 16'h0000;
            valid_q <= 1'b0;
            idx_q   <= 3'd0;
            last_q  <= 1'b1;
        end else begin
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    assign bus.ir_out    = ir_q;
    assign bus.pc_out    = pc_q;
    assign bus.valid_out = valid_q;
    assign bus.xfer_idx  = idx_q;
    assign bus.last_xfer = last_q;
    assign bus.busy      = (state_q == SEQ);
endmodule

// File: tb/tb_lmsm_sequencer.sv
// Randomized scoreboard bench for lmsm_sequencer: the driver expands each accepted
// instruction into its expected decode ops; the monitor checks every clock edge.
module tb_lmsm_sequencer;
    typedef struct {
        logic [15:0] ir;
        logic [15:0] pc;
        logic        v;
        logic [2:0]  idx;
        logic        last;
        logic        busy;
        logic        pc_chk;
    } exp_t;

    localparam int NCYC = 3000;
    localparam int NDIR = 6;

    logic clk;
    logic rst_n;
    lmsm_sequencer_if bus();

    lmsm_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: one op per set mask bit, the k-th op keeps the mask bits from the k-th set bit upward.
    function automatic void expand(input logic [15:0] ir, input logic [15:0] pc, input logic v);
        int         pos[$];
        exp_t       e;
        logic [7:0] m;
        for (int b = 0; b < 8; b++) if (ir[b]) pos.push_back(b);
        if (v && ir[15:13] == 3'b011 && pos.size() >= 2) begin
            for (int k = 0; k < pos.size(); k++) begin
                m = 8'd0;
                for (int j = k; j < pos.size(); j++) m[pos[j]] = 1'b1;
                e.ir = {ir[15:8], m}; e.pc = pc; e.v = 1'b1; e.idx = 3'(k);
                e.last = (k == pos.size() - 1); e.busy = !e.last; e.pc_chk = 1'b1;
                q.push_back(e);
            end
        end else begin
            e.ir = ir; e.pc = pc; e.v = v; e.idx = 3'd0;
            e.last = 1'b1; e.busy = 1'b0; e.pc_chk = 1'b1;
            q.push_back(e);
        end
    endfunction

    // Monitor
    initial begin
        logic r, f, s, ok;
        exp_t e, prev;
        prev.ir = 16'hF000; prev.pc = 16'h0; prev.v = 1'b0; prev.idx = 3'd0;
        prev.last = 1'b1; prev.busy = 1'b0; prev.pc_chk = 1'b0;
        forever begin
            @(posedge clk);
            r = rst_n; f = bus.flush; s = bus.stall_in;
            #1;
            e = prev;
            if (!r) begin
                e.ir = 16'hF000; e.pc = 16'h0; e.v = 1'b0; e.idx = 3'd0;
                e.last = 1'b1; e.busy = 1'b0; e.pc_chk = 1'b1;
            end else if (f) begin
                e.ir = 16'hF000; e.v = 1'b0; e.idx = 3'd0;
                e.last = 1'b1; e.busy = 1'b0; e.pc_chk = 1'b0;
            end else if (!s) begin
                if (q.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL underflow t=%0t: DUT updated with no expected op queued", $time);
                    continue;
                end
                e = q.pop_front();
            end
            n_chk++;
            ok = (bus.ir_out === e.ir) && (bus.valid_out === e.v) && (bus.xfer_idx === e.idx) &&
                 (bus.last_xfer === e.last) && (bus.busy === e.busy) &&
                 (!e.pc_chk || bus.pc_out === e.pc);
            if (!ok) begin
                n_err++;
                $display("FAIL %s t=%0t (got/exp): ir %h/%h pc %h/%h v %b/%b idx %0d/%0d last %b/%b busy %b/%b",
                         !r ? "reset" : f ? "flush" : s ? "stall" : "xfer", $time,
                         bus.ir_out, e.ir, bus.pc_out, e.pc, bus.valid_out, e.v,
                         bus.xfer_idx, e.idx, bus.last_xfer, e.last, bus.busy, e.busy);
            end
            prev = e;
        end
    end

    // Driver
    initial begin
        logic [15:0] dir_ir [NDIR];
        int          dir_act[NDIR];
        int          dir_sz [NDIR];
        logic [15:0] cur_ir, cur_pc;
        logic        cur_v, r, f, s, acc, acc_prev, quiet;
        int          cur_dir, dptr, act, act_sz, stall_left, sel;

        // action: 1 = stall two cycles, 2 = flush, 3 = reset, when q reaches the given size
        dir_ir[0] = 16'h0298; dir_act[0] = 0; dir_sz[0] = 0;
        dir_ir[1] = 16'h6A96; dir_act[1] = 0; dir_sz[1] = 0;
        dir_ir[2] = 16'h7E01; dir_act[2] = 0; dir_sz[2] = 0;
        dir_ir[3] = 16'h60FF; dir_act[3] = 1; dir_sz[3] = 4;
        dir_ir[4] = 16'h600F; dir_act[4] = 2; dir_sz[4] = 1;
        dir_ir[5] = 16'h6A96; dir_act[5] = 3; dir_sz[5] = 2;

        rst_n = 1'b0;
        bus.ir_in = 16'h0; bus.pc_in = 16'h0; bus.valid_in = 1'b0;
        bus.stall_in = 1'b0; bus.flush = 1'b0;
        dptr = 0; act = 0; act_sz = 0; stall_left = 0;
        acc_prev = 1'b1; cur_ir = 16'h0; cur_pc = 16'h0; cur_v = 1'b0; cur_dir = -1;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            quiet = (cyc >= NCYC - 16);
            if (acc_prev) begin
                cur_pc = 16'($urandom);
                if (dptr < NDIR && !quiet) begin
                    cur_ir = dir_ir[dptr]; cur_v = 1'b1; cur_dir = dptr; dptr++;
                end else begin
                    sel = $urandom_range(0, 7);
                    cur_ir = 16'($urandom);
                    if ($urandom_range(0, 1) == 1) cur_ir[15:12] = ($urandom_range(0, 1) == 1) ? 4'h6 : 4'h7;
                    if (sel == 0) cur_ir[7:0] = 8'h00;
                    else if (sel == 1) cur_ir[7:0] = 8'(1 << $urandom_range(0, 7));
                    cur_v = quiet ? 1'b0 : ($urandom_range(0, 7) != 0);
                    cur_dir = -1;
                end
            end
            r = 1'b1; f = 1'b0; s = 1'b0;
            if (cyc < 2) begin
                r = 1'b0;
            end else if (stall_left > 0) begin
                s = 1'b1; stall_left--;
            end else if (act != 0 && q.size() == act_sz) begin
                if (act == 1) begin s = 1'b1; stall_left = 1; end
                else if (act == 2) f = 1'b1;
                else r = 1'b0;
                act = 0;
            end else if (dptr >= NDIR && !quiet) begin
                r = ($urandom_range(0, 199) != 0);
                f = ($urandom_range(0, 19) == 0);
                s = ($urandom_range(0, 7) == 0);
            end
            if (!r || f) q.delete();
            acc = r && !f && !s && (q.size() == 0);
            if (acc) begin
                expand(cur_ir, cur_pc, cur_v);
                if (cur_dir >= 0) begin act = dir_act[cur_dir]; act_sz = dir_sz[cur_dir]; end
                else act = 0;
            end
            acc_prev = acc;
            rst_n = r; bus.flush = f; bus.stall_in = s;
            bus.ir_in = cur_ir; bus.pc_in = cur_pc; bus.valid_in = cur_v;
        end
        @(posedge clk);
        #2;
        n_chk++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected ops never presented, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
